// File: rtl/mesh_feeder_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : mesh_pkg
//  Description : Shared types and constants for the 2x2 mesh feeder.
//                Holds the FSM state encoding, the feed schedule constants,
//                the default coefficient width and a helper that extracts
//                A[r][c] from a packed 2x2 matrix vector.
//  Options     : none (the queue option MESH_FEEDER_QUEUE_EN lives in the
//                top and the job latch)
//  Revision    : 1.0  initial release
// ============================================================================
package mesh_pkg;

  localparam int DW_DEFAULT = 4;   // mesh operand width
  localparam int MAX_DW     = 16;  // widest coefficient mat_elem can extract
  localparam int FEED_LAST  = 4;   // last FEED step index
  localparam int K_STEPS    = 2;   // steps that carry operands (inner dimension)
  localparam int STEP_W     = 3;   // width of the FEED step counter

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Element A[r][c] sits at bits dw*(2r+c) +: dw. The vector is handled at
  // MAX_DW granularity so one function serves every legal DW; callers
  // zero-extend the input and truncate the result.
  function automatic logic [MAX_DW-1:0] mat_elem(
    input logic [4*MAX_DW-1:0] vec,
    input int                  dw,
    input int                  r,
    input int                  c
  );
    logic [4*MAX_DW-1:0] sh;
    sh = vec >> (dw * (2 * r + c));
    // For dw == MAX_DW the shift wraps to zero and the mask becomes all ones.
    return sh[MAX_DW-1:0] & ((MAX_DW'(1) << dw) - MAX_DW'(1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/mesh_feeder_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : mesh_feeder_ctrl_if
//  Description : Job handshake and mesh-side bundle of the mesh feeder.
//  Signals     : START, MA, MB        job request and packed operands
//                READY                feeder can accept a job
//                A00, A10, B00, B01   operand streams to the mesh
//                ENp, ENq, ENa, ENr   mesh enables
//                DONE                 one-cycle "results valid" pulse
//  Modports    : master - job source / mesh side (drives START, MA, MB)
//                slave  - the feeder (drives everything else)
//  Revision    : 1.0  initial release
// ============================================================================
interface mesh_feeder_ctrl_if
  import mesh_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) ();

  logic            START;
  logic [4*DW-1:0] MA;
  logic [4*DW-1:0] MB;
  logic            READY;
  logic [DW-1:0]   A00;
  logic [DW-1:0]   A10;
  logic [DW-1:0]   B00;
  logic [DW-1:0]   B01;
  logic            ENp;
  logic            ENq;
  logic [3:0]      ENa;
  logic [3:0]      ENr;
  logic            DONE;

  modport master (
    output START, MA, MB,
    input  READY, A00, A10, B00, B01, ENp, ENq, ENa, ENr, DONE
  );

  modport slave (
    input  START, MA, MB,
    output READY, A00, A10, B00, B01, ENp, ENq, ENa, ENr, DONE
  );

endinterface
`default_nettype wire

// File: rtl/mesh_feeder_ctrl_job_latch.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_job_latch
//  Description : Operand latch for the running job, plus an optional
//                one-entry job queue when MESH_FEEDER_QUEUE_EN is defined.
//                job_ma/job_mb present the operand set that will be in the
//                latch after the coming edge, so the top can register the
//                t=0 operands on the accept edge itself.
//  Ports       : CLK, RST        clock, async active-high reset
//                load            take MA/MB straight into the latch
//                ma, mb          packed operands from the job source
//                push, pop       queue write / queue-to-latch move (option)
//                q_valid         queue holds a job (option)
//                job_ma, job_mb  operand set for the next cycle
//  Options     : MESH_FEEDER_QUEUE_EN adds the queue entry
//  Revision    : 1.0  initial release
// ============================================================================
module mesh_job_latch
  import mesh_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  wire logic            CLK,
  input  wire logic            RST,
  input  wire logic            load,
  input  wire logic [4*DW-1:0] ma,
  input  wire logic [4*DW-1:0] mb,
`ifdef MESH_FEEDER_QUEUE_EN
  input  wire logic            push,
  input  wire logic            pop,
  output logic                 q_valid,
`endif
  output logic [4*DW-1:0]      job_ma,
  output logic [4*DW-1:0]      job_mb
);

  logic [4*DW-1:0] cur_ma;
  logic [4*DW-1:0] cur_mb;

`ifdef MESH_FEEDER_QUEUE_EN
  logic [4*DW-1:0] q_ma;
  logic [4*DW-1:0] q_mb;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_ma    <= '0;
      q_mb    <= '0;
      q_valid <= 1'b0;
    end else if (push) begin
      q_ma    <= ma;
      q_mb    <= mb;
      q_valid <= 1'b1;
    end else if (pop) begin
      q_valid <= 1'b0;
    end
  end
`endif

  always_comb begin
    job_ma = cur_ma;
    job_mb = cur_mb;
    if (load) begin
      job_ma = ma;
      job_mb = mb;
    end
`ifdef MESH_FEEDER_QUEUE_EN
    else if (pop) begin
      job_ma = q_ma;
      job_mb = q_mb;
    end
`endif
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cur_ma <= '0;
      cur_mb <= '0;
    end else begin
      cur_ma <= job_ma;
      cur_mb <= job_mb;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mesh_feeder_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mesh_feeder_ctrl
//  Description : Sequencer for the 2x2 systolic matrix-multiply mesh.
//                Accepts a pair of 2x2 operand matrices, streams rows of A
//                and columns of B onto the mesh ports over FEED steps 0..1,
//                drives the mesh enables on a fixed 5-step schedule and then
//                pulses DONE for one cycle once the mesh holds C = A*B.
//  Ports       : CLK   clock, rising edge
//                RST   async active-high reset
//                bus   mesh_feeder_ctrl_if.slave (handshake, operand
//                      streams, enables, DONE)
//  Options     : MESH_FEEDER_QUEUE_EN adds a one-entry job queue so a job
//                can be accepted while another one is being fed.
//  Revision    : 1.0  initial release
// ============================================================================
module mesh_feeder_ctrl
  import mesh_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  wire logic         CLK,
  input  wire logic         RST,
  mesh_feeder_ctrl_if.slave bus
);

  state_t              state;
  state_t              state_nxt;
  logic [STEP_W-1:0]   step;
  logic [STEP_W-1:0]   step_nxt;

  logic                accept;
  logic                load_direct;
  logic [4*DW-1:0]     job_ma;
  logic [4*DW-1:0]     job_mb;

  logic                ready_nxt;
  logic                done_nxt;
  logic [DW-1:0]       a00_nxt;
  logic [DW-1:0]       a10_nxt;
  logic [DW-1:0]       b00_nxt;
  logic [DW-1:0]       b01_nxt;
  logic                enp_nxt;
  logic                enq_nxt;
  logic [3:0]          ena_nxt;
  logic [3:0]          enr_nxt;

`ifdef MESH_FEEDER_QUEUE_EN
  logic                q_valid;
  logic                q_push;
  logic                q_pop;
`endif

  // READY is itself a register, so the handshake never loops back
  // combinationally through the feeder.
  assign accept = bus.START & bus.READY;

  mesh_job_latch #(
    .DW (DW)
  ) u_job_latch (
    .CLK     (CLK),
    .RST     (RST),
    .load    (load_direct),
    .ma      (bus.MA),
    .mb      (bus.MB),
`ifdef MESH_FEEDER_QUEUE_EN
    .push    (q_push),
    .pop     (q_pop),
    .q_valid (q_valid),
`endif
    .job_ma  (job_ma),
    .job_mb  (job_mb)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      step  <= '0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt   = state;
    step_nxt    = step;
    load_direct = 1'b0;
`ifdef MESH_FEEDER_QUEUE_EN
    q_push      = 1'b0;
    q_pop       = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        step_nxt = '0;
        if (accept) begin
          state_nxt   = ST_FEED;
          load_direct = 1'b1;
        end
      end
      ST_FEED: begin
        if (step == STEP_W'(FEED_LAST)) begin
          state_nxt = ST_DONE;
          step_nxt  = '0;
        end else begin
          step_nxt = step + STEP_W'(1);
        end
`ifdef MESH_FEEDER_QUEUE_EN
        // The running job owns the latch; a new job waits in the queue.
        q_push = accept;
`endif
      end
      ST_DONE: begin
        step_nxt = '0;
        if (accept) begin
          state_nxt   = ST_FEED;
          load_direct = 1'b1;
        end
`ifdef MESH_FEEDER_QUEUE_EN
        else if (q_valid) begin
          state_nxt = ST_FEED;
          q_pop     = 1'b1;
        end
`endif
        else begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        step_nxt  = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode from the next state, registered below so every output
  // comes straight from a flop.
  // --------------------------------------------------------------------------
  always_comb begin
    a00_nxt  = '0;
    a10_nxt  = '0;
    b00_nxt  = '0;
    b01_nxt  = '0;
    enp_nxt  = 1'b0;
    enq_nxt  = 1'b0;
    ena_nxt  = 4'b0000;
    enr_nxt  = 4'b0000;
    done_nxt = (state_nxt == ST_DONE);

`ifdef MESH_FEEDER_QUEUE_EN
    ready_nxt = ~(q_push | (q_valid & ~q_pop));
`else
    ready_nxt = (state_nxt != ST_FEED);
`endif

    if (state_nxt == ST_FEED) begin
      // Step k carries column k of A and row k of B. job_ma/job_mb already
      // reflect a load happening on this edge, so t=0 gets the new job.
      for (int k = 0; k < K_STEPS; k++) begin
        if (step_nxt == STEP_W'(k)) begin
          a00_nxt = DW'(mat_elem((4*MAX_DW)'(job_ma), DW, 0, k));
          a10_nxt = DW'(mat_elem((4*MAX_DW)'(job_ma), DW, 1, k));
          b00_nxt = DW'(mat_elem((4*MAX_DW)'(job_mb), DW, k, 0));
          b01_nxt = DW'(mat_elem((4*MAX_DW)'(job_mb), DW, k, 1));
        end
      end

      // MAC 00 is fed directly, MACs 01/10 one hop later, MAC 11 two hops
      // later; each result is captured on the step after its last add.
      case (step_nxt)
        STEP_W'(0): begin
          enp_nxt = 1'b1;
          ena_nxt = 4'b0001;
        end
        STEP_W'(1): begin
          enp_nxt = 1'b1;
          enq_nxt = 1'b1;
          ena_nxt = 4'b0111;
        end
        STEP_W'(2): begin
          enq_nxt = 1'b1;
          ena_nxt = 4'b1110;
          enr_nxt = 4'b0001;
        end
        STEP_W'(3): begin
          ena_nxt = 4'b1000;
          enr_nxt = 4'b0110;
        end
        STEP_W'(4): begin
          enr_nxt = 4'b1000;
        end
        default: begin
          enp_nxt = 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.READY <= 1'b1;
      bus.DONE  <= 1'b0;
      bus.A00   <= '0;
      bus.A10   <= '0;
      bus.B00   <= '0;
      bus.B01   <= '0;
      bus.ENp   <= 1'b0;
      bus.ENq   <= 1'b0;
      bus.ENa   <= 4'b0000;
      bus.ENr   <= 4'b0000;
    end else begin
      bus.READY <= ready_nxt;
      bus.DONE  <= done_nxt;
      bus.A00   <= a00_nxt;
      bus.A10   <= a10_nxt;
      bus.B00   <= b00_nxt;
      bus.B01   <= b01_nxt;
      bus.ENp   <= enp_nxt;
      bus.ENq   <= enq_nxt;
      bus.ENa   <= ena_nxt;
      bus.ENr   <= enr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: doc/mesh_feeder_ctrl.md
Name: mesh_feeder_ctrl

Overview:
- Upstream sequencer for the 2x2 systolic matrix-multiply mesh.
- Accepts two complete 2x2 operand matrices through a START/READY handshake.
- Streams them as aligned rows/columns onto the mesh operand ports (A00, A10, B00, B01).
- Generates every mesh enable (ENp, ENq, ENa, ENr) on a fixed schedule, then pulses DONE once the mesh result registers hold C = A·B.

Parameters:
- DW, 4: coefficient width in bits; must match the mesh operand width.

Ports:
- RST  in  1  async active-high reset
- CLK  in  1  master clock, rising edge
- START  in  1  job request; accepted on an edge where START=1 and READY=1
- MA  in  4*DW  matrix A, packed: A[r][c] at bits DW*(2r+c) +: DW
- MB  in  4*DW  matrix B, same packing
- READY  out  1  feeder can accept a job
- A00  out  DW  row 0 of A stream to mesh
- A10  out  DW  row 1 of A stream to mesh
- B00  out  DW  column 0 of B stream to mesh
- B01  out  DW  column 1 of B stream to mesh
- ENp  out  1  mesh first-hop pipeline register enable
- ENq  out  1  mesh second-hop (coef 11) register enable
- ENa  out  4  MAC accumulate enables, index 0..3 = coef 00, 01, 10, 11
- ENr  out  4  MAC result-capture enables, same indexing
- DONE  out  1  one-cycle pulse: all mesh results valid

Behaviour:
- Clock and reset: one clock CLK; RST is asynchronous, active-high.
- Reset values: all outputs 0 except READY=1; FSM in IDLE; operand latch cleared.
- Mesh contract:
  - ENa[i]=1: MAC i adds operand product into its accumulator on that edge.
  - ENr[i]=1: MAC i result register captures the accumulated sum, and the accumulator restarts from zero.
- Accept: on the edge where START=1 and READY=1, MA/MB are latched internally. Later MA/MB changes have no effect on the running job.
- States:
  - IDLE: READY=1. On accept, go to FEED with step counter t=0.
  - FEED: t counts 0..4, one cycle per step. READY=0. After t=4, go to DONE.
  - DONE: one cycle. DONE=1, READY=1. Next state is FEED (t=0) if a new job is accepted this edge, otherwise IDLE.
- Operand streaming, FEED step t=k for k in {0,1}:
  - A00=A[0][k], A10=A[1][k], B00=B[k][0], B01=B[k][1].
  - All four ports are 0 at every other step and state.
- Enable schedule, high only in the listed FEED steps:
  - ENp: t=0,1
  - ENq: t=1,2
  - ENa[0]: t=0,1
  - ENa[1], ENa[2]: t=1,2
  - ENa[3]: t=2,3
  - ENr[0]: t=2
  - ENr[1], ENr[2]: t=3
  - ENr[3]: t=4
- Latency: accept edge to DONE cycle is 6 cycles. Mesh outputs MTX00..MTX11 are stable from the DONE cycle until the next job's ENr.
- All outputs are registered; no combinational path from inputs to outputs.
- START while READY=0: ignored, no queuing (unless the optional feature is enabled).
- Arithmetic: the feeder does no arithmetic. Mesh 8-bit sums wrap mod 256; the feeder does not detect overflow.
- Reset mid-FEED: outputs drop to reset values immediately (async). The partial job is discarded and no DONE is issued. The mesh accumulators are cleared by the shared RST.

Optional Feature:
- Macro: MESH_FEEDER_QUEUE_EN.
- Defined:
  - Adds a one-entry job queue (MA, MB, valid flag).
  - READY=1 whenever the queue is empty, including during FEED.
  - A START accepted during FEED is queued. At the end of DONE, a queued job starts FEED t=0 on the next cycle and the queue empties.
  - Queue full → READY=0 until it drains.
  - RST clears the queue.
- Undefined: READY exactly as in Behaviour (IDLE and DONE only).

Decomposition:
- Shared package mesh_pkg holds:
  - state encoding (IDLE, FEED, DONE)
  - step constants: FEED_LAST=4, K_STEPS=2
  - the default DW
  - a function to extract A[r][c] from the packed vector
- Natural sub-module: mesh_job_latch, the operand latch plus optional queue entry, holding MA/MB/valid. The FSM and enable decode stay in the top module.

Test Plan:
- Reset then idle: RST pulse, no START → READY=1, all streams/enables 0, DONE never asserted.
- Single job: A=[[1,2],[3,4]], B=[[5,6],[7,8]], START for 1 cycle.
  - t=0 ports: A00=1, A10=3, B00=5, B01=6. t=1 ports: A00=2, A10=4, B00=7, B01=8.
  - Enables match the schedule; DONE exactly 6 cycles after accept.
  - Mesh in loop: MTX00=19, MTX01=22, MTX10=43, MTX11=50.
- Busy START: second START at t=2 with A=I, B=I → ignored. Only one DONE; the next job runs only after READY returns.
- Back-to-back: START held high through the DONE cycle with new A=[[15,15],[15,15]], B=same.
  - FEED restarts the next cycle.
  - Mesh results 450 mod 256 = 194 in all four outputs.
- Reset mid-job: RST asserted at t=2 → outputs 0 within the same cycle, no DONE. A fresh job after release completes correctly.
- MESH_FEEDER_QUEUE_EN: START jobs J1 and J2 (J2 at J1 t=1) → READY=0 after J2 is queued. J2 FEED begins the cycle after J1's DONE, giving two DONE pulses 6 cycles apart.
